// File: rtl/oam_dma_sched.sv
// oam_dma_sched: OAM DMA sequencer. An FF46 write copies OAM_LEN bytes from page {FF46,8'h00} into OAM,
// and flags CPU and PPU bus contention while the copy runs.
module oam_dma_sched #(
    parameter int OAM_LEN       = 160,
    parameter int CLKS_PER_BYTE = 4,
    parameter int START_DELAY   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ADDR,
    input  logic        WR,
    input  logic [7:0]  MMIO_DATA_out,
    output logic [7:0]  MMIO_DATA_in,
    output logic        DMA_RD,
    output logic [15:0] DMA_ADDR,
    input  logic [7:0]  DMA_DATA_in,
    output logic        OAM_WR,
    output logic [7:0]  OAM_ADDR,
    output logic [7:0]  OAM_DATA,
    output logic        DMA_ACTIVE,
    output logic        CPU_BLOCK,
    output logic        PPU_OAM_BLOCK
);
    typedef enum logic [1:0] {IDLE, DELAY, XFER} state_t;
    state_t     state_q, state_d;
    logic [7:0] src_q, src_d, idx_q, idx_d, k_q, k_d, dcnt_q, dcnt_d, data_q, data_d;
    logic [7:0] page;
    logic       ff46_wr, last_slot, xfer;
    assign ff46_wr   = WR && ADDR == 16'hFF46;
    assign xfer      = state_q == XFER;
    assign last_slot = k_q == 8'(CLKS_PER_BYTE - 1);
    // Echo pages E0-FF fold onto C0-DF.
    assign page          = src_q < 8'hE0 ? src_q : src_q - 8'h20;
    assign MMIO_DATA_in  = ADDR == 16'hFF46 ? src_q : 8'hFF;
    assign DMA_RD        = xfer && k_q == 8'd0;
    assign DMA_ADDR      = {page, idx_q};
    assign OAM_WR        = xfer && last_slot;
    assign OAM_ADDR      = idx_q;
    assign OAM_DATA      = data_q;
    assign DMA_ACTIVE    = state_q != IDLE;
    assign PPU_OAM_BLOCK = xfer;
    assign CPU_BLOCK     = xfer && !(ADDR >= 16'hFF80 && ADDR <= 16'hFFFE);
    always_comb begin
        state_d = state_q;
        src_d   = ff46_wr ? MMIO_DATA_out : src_q;
        idx_d   = idx_q;
        k_d     = k_q;
        dcnt_d  = dcnt_q;
        data_d  = (xfer && k_q == 8'd1) ? DMA_DATA_in : data_q;
        if (ff46_wr) begin
            state_d = DELAY;
            dcnt_d  = 8'(START_DELAY - 1);
            idx_d   = 8'd0;
            k_d     = 8'd0;
        end else if (state_q == DELAY) begin
            dcnt_d = dcnt_q - 8'd1;
            if (dcnt_q == 8'd0) begin
                state_d = XFER;
                idx_d   = 8'd0;
                k_d     = 8'd0;
            end
        end else if (xfer) begin
            k_d = last_slot ? 8'd0 : k_q + 8'd1;
            if (last_slot) begin
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'(OAM_LEN - 1)) begin
                    state_d = IDLE;
                    idx_d   = 8'd0;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            src_q   <= 8'd0;
            idx_q   <= 8'd0;
            k_q     <= 8'd0;
            dcnt_q  <= 8'd0;
            data_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            dcnt_q  <= dcnt_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_oam_dma_sched.sv
// tb_oam_dma_sched: directed tests for the OAM DMA sequencer at default and reduced timing.
module tb_oam_dma_sched;
    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] addr = 16'h0000, addr2 = 16'h0000;
    logic        wr = 1'b0, wr2 = 1'b0;
    logic [7:0]  wdata = 8'h00, wdata2 = 8'h00;
    logic [7:0]  rdata, rdata2, din = 8'hEE, din2 = 8'hEE;
    logic        dma_rd, rd2, oam_wr, owr2, act, act2, cblk, cblk2, pblk, pblk2;
    logic [15:0] daddr, daddr2;
    logic [7:0]  oaddr, oaddr2, odata, odata2;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    oam_dma_sched dut (
        .clk(clk), .rst(rst), .ADDR(addr), .WR(wr), .MMIO_DATA_out(wdata), .MMIO_DATA_in(rdata),
        .DMA_RD(dma_rd), .DMA_ADDR(daddr), .DMA_DATA_in(din), .OAM_WR(oam_wr), .OAM_ADDR(oaddr),
        .OAM_DATA(odata), .DMA_ACTIVE(act), .CPU_BLOCK(cblk), .PPU_OAM_BLOCK(pblk)
    );
    oam_dma_sched #(.OAM_LEN(160), .CLKS_PER_BYTE(3), .START_DELAY(1)) dut2 (
        .clk(clk), .rst(rst), .ADDR(addr2), .WR(wr2), .MMIO_DATA_out(wdata2), .MMIO_DATA_in(rdata2),
        .DMA_RD(rd2), .DMA_ADDR(daddr2), .DMA_DATA_in(din2), .OAM_WR(owr2), .OAM_ADDR(oaddr2),
        .OAM_DATA(odata2), .DMA_ACTIVE(act2), .CPU_BLOCK(cblk2), .PPU_OAM_BLOCK(pblk2)
    );

    // Source memory contents: page C1 holds i^5A, other pages are distinguishable.
    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'hC1;
    endfunction

    always @(posedge clk) din  <= dma_rd ? src_byte(daddr) : 8'hEE;
    always @(posedge clk) din2 <= rd2 ? src_byte(daddr2) : 8'hEE;

    task automatic cpu_write(input logic [7:0] d);
        @(negedge clk);
        addr = 16'hFF46; wr = 1'b1; wdata = d;
        @(negedge clk);
        wr = 1'b0; addr = 16'h0000;
    endtask

    // Observes one transfer from the negedge right after the FF46 write until DMA_ACTIVE drops.
    task automatic run1(input logic [7:0] page, output int a, output int rds, output int wrs,
                        output int fw, output int fr, output int bad);
        int cyc = 0;
        a = 0; rds = 0; wrs = 0; fw = -1; fr = -1; bad = 0;
        while (act && cyc < 2000) begin
            a++;
            if (dma_rd) begin
                if (fr < 0) fr = cyc;
                if (daddr !== {page, 8'(rds)}) bad++;
                rds++;
            end
            if (oam_wr) begin
                if (fw < 0) fw = cyc;
                if (oaddr !== 8'(wrs) || odata !== src_byte({page, 8'(wrs)})) bad++;
                wrs++;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_wr(input int i);
        int n = 0;
        while (!(oam_wr && oaddr == 8'(i)) && n < 2000) begin @(negedge clk); n++; end
        checks++; if (!(oam_wr && oaddr == 8'(i))) begin errors++; $display("FAIL wait_wr_%0d timed out", i); end
    endtask

    task automatic wait_idle;
        int n = 0;
        while (act && n < 2000) begin @(negedge clk); n++; end
        checks++; if (act) begin errors++; $display("FAIL idle_timeout act stuck at 1"); end
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        addr = 16'hFF46;
        #1;
        checks++; if ({dma_rd, oam_wr, act, cblk, pblk, daddr, oaddr, odata, rdata} !== 45'd0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", {dma_rd, oam_wr, act, cblk, pblk, daddr, oaddr, odata, rdata}); end
        @(negedge clk); rst = 1'b1;
        addr = 16'hFF47; wr = 1'b1; wdata = 8'h55;
        @(negedge clk); wr = 1'b0; addr = 16'hFF46;
        #1;
        checks++; if ({act, rdata} !== 9'h000) begin errors++; $display("FAIL other_addr_ignored got %h exp 000", {act, rdata}); end
        addr = 16'h0000;
        #1;
        checks++; if (rdata !== 8'hFF) begin errors++; $display("FAIL readback_other got %h exp FF", rdata); end
    endtask

    task automatic test_basic;
        int a, rds, wrs, fw, fr, bad;
        cpu_write(8'hC1);
        run1(8'hC1, a, rds, wrs, fw, fr, bad);
        checks++; if (a !== 644) begin errors++; $display("FAIL basic_active got %0d exp 644", a); end
        checks++; if (rds !== 160) begin errors++; $display("FAIL basic_rd_count got %0d exp 160", rds); end
        checks++; if (wrs !== 160) begin errors++; $display("FAIL basic_wr_count got %0d exp 160", wrs); end
        checks++; if (fw !== 7) begin errors++; $display("FAIL basic_first_wr got %0d exp 7", fw); end
        checks++; if (fr !== 4) begin errors++; $display("FAIL basic_first_rd got %0d exp 4", fr); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL basic_data got %0d bad exp 0", bad); end
    endtask

    task automatic test_mirror;
        int a, rds, wrs, fw, fr, bad;
        cpu_write(8'hFE);
        addr = 16'hFF46;
        #1;
        checks++; if (rdata !== 8'hFE) begin errors++; $display("FAIL mirror_readback got %h exp FE", rdata); end
        addr = 16'h0000;
        #1;
        run1(8'hDE, a, rds, wrs, fw, fr, bad);
        checks++; if (rds !== 160 || bad !== 0) begin errors++; $display("FAIL mirror_addr got rds=%0d bad=%0d exp 160/0", rds, bad); end
        checks++; if (a !== 644) begin errors++; $display("FAIL mirror_active got %0d exp 644", a); end
    endtask

    task automatic test_restart;
        int a, rds, wrs, fw, fr, bad;
        cpu_write(8'hC0);
        wait_wr(80);
        checks++; if (odata !== src_byte(16'hC050)) begin errors++; $display("FAIL restart_inflight got %h exp %h", odata, src_byte(16'hC050)); end
        addr = 16'hFF46; wr = 1'b1; wdata = 8'hD0;
        @(negedge clk); wr = 1'b0; addr = 16'h0000;
        checks++; if ({act, pblk} !== 2'b10) begin errors++; $display("FAIL restart_delay got %b exp 10", {act, pblk}); end
        run1(8'hD0, a, rds, wrs, fw, fr, bad);
        checks++; if (fr !== 4) begin errors++; $display("FAIL restart_first_rd got %0d exp 4", fr); end
        checks++; if (wrs !== 160 || bad !== 0) begin errors++; $display("FAIL restart_writes got wrs=%0d bad=%0d exp 160/0", wrs, bad); end
        checks++; if (a !== 644) begin errors++; $display("FAIL restart_active got %0d exp 644", a); end
    endtask

    task automatic test_back_to_back;
        int a, rds, wrs, fw, fr, bad;
        cpu_write(8'hC1);
        wait_wr(159);
        addr = 16'hFF46; wr = 1'b1; wdata = 8'hC2;
        @(negedge clk); wr = 1'b0; addr = 16'h0000;
        checks++; if (act !== 1'b1) begin errors++; $display("FAIL b2b_active got %b exp 1", act); end
        run1(8'hC2, a, rds, wrs, fw, fr, bad);
        checks++; if (fr !== 4 || wrs !== 160 || bad !== 0 || a !== 644) begin
            errors++; $display("FAIL b2b_xfer got fr=%0d wrs=%0d bad=%0d act=%0d exp 4/160/0/644", fr, wrs, bad, a); end
    endtask

    task automatic test_blocking;
        cpu_write(8'hC1);
        addr = 16'hC000;
        #1;
        checks++; if ({cblk, pblk, act} !== 3'b001) begin errors++; $display("FAIL block_delay got %b exp 001", {cblk, pblk, act}); end
        repeat (5) @(negedge clk);
        addr = 16'hFF90; #1;
        checks++; if ({cblk, pblk} !== 2'b01) begin errors++; $display("FAIL block_hram got %b exp 01", {cblk, pblk}); end
        addr = 16'hC000; #1;
        checks++; if ({cblk, pblk} !== 2'b11) begin errors++; $display("FAIL block_wram got %b exp 11", {cblk, pblk}); end
        addr = 16'hFFFF; #1;
        checks++; if (cblk !== 1'b1) begin errors++; $display("FAIL block_ffff got %b exp 1", cblk); end
        addr = 16'hFF80; #1;
        checks++; if (cblk !== 1'b0) begin errors++; $display("FAIL block_ff80 got %b exp 0", cblk); end
        addr = 16'hFFFE; #1;
        checks++; if (cblk !== 1'b0) begin errors++; $display("FAIL block_fffe got %b exp 0", cblk); end
        addr = 16'h0000;
        wait_idle;
        addr = 16'hC000; #1;
        checks++; if ({cblk, pblk} !== 2'b00) begin errors++; $display("FAIL block_idle got %b exp 00", {cblk, pblk}); end
        addr = 16'h0000;
    endtask

    task automatic test_reset_mid;
        int n = 0;
        cpu_write(8'hC1);
        wait_wr(50);
        rst = 1'b0; addr = 16'hFF46;
        #1;
        checks++; if ({dma_rd, oam_wr, act, cblk, pblk, daddr, oaddr, odata, rdata} !== 45'd0) begin
            errors++; $display("FAIL reset_mid got %h exp 0", {dma_rd, oam_wr, act, cblk, pblk, daddr, oaddr, odata, rdata}); end
        addr = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (40) begin @(negedge clk); if (oam_wr || act) n++; end
        checks++; if (n !== 0) begin errors++; $display("FAIL reset_mid_after got %0d active cycles exp 0", n); end
    endtask

    task automatic test_param;
        int a = 0, wrs = 0, fw = -1, last = 0, gap = 0, bad = 0, cyc = 0;
        @(negedge clk); addr2 = 16'hFF46; wr2 = 1'b1; wdata2 = 8'hC1;
        @(negedge clk); wr2 = 1'b0; addr2 = 16'h0000;
        while (act2 && cyc < 2000) begin
            a++;
            if (owr2) begin
                if (fw < 0) fw = cyc; else if (cyc - last != 3) gap++;
                last = cyc;
                if (oaddr2 !== 8'(wrs) || odata2 !== src_byte({8'hC1, 8'(wrs)})) bad++;
                wrs++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++; if (a !== 481) begin errors++; $display("FAIL param_active got %0d exp 481", a); end
        checks++; if (fw !== 3) begin errors++; $display("FAIL param_first_wr got %0d exp 3", fw); end
        checks++; if (wrs !== 160 || gap !== 0 || bad !== 0) begin
            errors++; $display("FAIL param_writes got wrs=%0d gap=%0d bad=%0d exp 160/0/0", wrs, gap, bad); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_mirror;
        test_restart;
        test_back_to_back;
        test_blocking;
        test_reset_mid;
        test_param;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
